// File: rtl/spi_slave_stream_if.sv
// SPI pin and tx/rx stream bundle for spi_slave_stream.
// slave: DUT view; master: SPI master plus stream producer/consumer view.
`timescale 1ns/1ps
interface spi_slave_stream_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  sclk;
  logic                  cs_bar;
  logic                  mosi;
  logic                  miso;
  logic                  miso_oe;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  busy;
  logic                  tx_underrun;
  logic                  rx_overrun;
  logic                  frame_abort;

  modport slave (
    input  sclk, cs_bar, mosi,
    input  tx_data, tx_valid, rx_ready,
    output miso, miso_oe,
    output tx_ready, rx_data, rx_valid,
    output busy, tx_underrun,
    output rx_overrun, frame_abort
  );

  modport master (
    output sclk, cs_bar, mosi,
    output tx_data, tx_valid, rx_ready,
    input  miso, miso_oe,
    input  tx_ready, rx_data, rx_valid,
    input  busy, tx_underrun,
    input  rx_overrun, frame_abort
  );
endinterface

// File: rtl/spi_slave_stream.sv
// SPI slave with synchronised pins, streaming multi-word frames, tx/rx holding regs.
// Ports: clk, reset (async active-low), bus (spi_slave_stream_if.slave: pins + streams).
`timescale 1ns/1ps
module spi_slave_stream #(
  parameter int DATA_WIDTH  = 16,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int LSB_FIRST   = 0,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic reset,
  spi_slave_stream_if.slave bus
);
  localparam int   CW   = $clog2(DATA_WIDTH + 1);
  localparam int   FW   = $clog2(SYNC_STAGES + 1);
  localparam logic IDLV = (CPOL != 0);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DRAIN
  } state_t;

  state_t r_state, w_next;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic r_sclk_prev;
  logic [FW-1:0] r_fill;
  logic r_armed;

  logic [DATA_WIDTH-1:0] r_hold, r_tx_shift, r_rx_shift, r_rx_data;
  logic r_hold_full, r_rx_valid, r_skip;
  logic [CW-1:0] r_bit_cnt;
  logic r_miso, r_oe, r_underrun, r_overrun, r_abort;

  logic w_sclk, w_cs, w_mosi, w_lead, w_trail;
  logic w_sample, w_drive;
  logic w_load, w_first, w_smp, w_shift, w_done, w_abort;
  logic [DATA_WIDTH-1:0] w_rx_next, w_tx_adv;
  logic w_tx_bit;

  assign w_sclk  = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs    = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi  = r_mosi_sync[SYNC_STAGES-1];
  assign w_lead  = (r_sclk_prev == IDLV) && (w_sclk != IDLV);
  assign w_trail = (r_sclk_prev != IDLV) && (w_sclk == IDLV);
  assign w_sample = (CPHA != 0) ? w_trail : w_lead;
  assign w_drive  = (CPHA != 0) ? w_lead : w_trail;

  assign w_rx_next = (LSB_FIRST != 0) ?
    {w_mosi, r_rx_shift[DATA_WIDTH-1:1]} :
    {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
  assign w_tx_adv = (LSB_FIRST != 0) ?
    {1'b0, r_tx_shift[DATA_WIDTH-1:1]} :
    {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
  assign w_tx_bit = (LSB_FIRST != 0) ?
    r_tx_shift[0] : r_tx_shift[DATA_WIDTH-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sclk_sync <= {SYNC_STAGES{IDLV}};
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_prev <= IDLV;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs_bar};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      r_sclk_prev <= w_sclk;
    end
  end

  // A frame may only start after cs_bar has been seen high through a
  // fully refilled synchroniser, so a frame cut by reset is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fill  <= '0;
      r_armed <= 1'b0;
    end else begin
      if (r_fill != FW'(SYNC_STAGES)) r_fill <= r_fill + 1'b1;
      if (w_first) r_armed <= 1'b0;
      else if (w_cs && r_fill == FW'(SYNC_STAGES)) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_first = 1'b0;
    w_smp   = 1'b0;
    w_shift = 1'b0;
    w_done  = 1'b0;
    w_abort = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_armed && !w_cs) begin
          w_next  = SHIFT;
          w_load  = 1'b1;
          w_first = 1'b1;
        end
      end
      SHIFT: begin
        if (w_cs) begin
          w_next  = DRAIN;
          w_abort = (r_bit_cnt != '0);
        end else if (w_sample) begin
          w_smp = 1'b1;
          if (r_bit_cnt == CW'(DATA_WIDTH - 1)) begin
            w_done = 1'b1;
            w_load = 1'b1;
          end
        end else if (w_drive && !r_skip) begin
          w_shift = 1'b1;
        end
      end
      DRAIN: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_bit_cnt   <= '0;
      r_skip      <= 1'b0;
      r_miso      <= 1'b0;
      r_oe        <= 1'b0;
      r_underrun  <= 1'b0;
      r_overrun   <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_underrun <= w_load & ~r_hold_full;
      r_overrun  <= w_done & r_rx_valid & ~bus.rx_ready;
      r_abort    <= w_abort;

      if (w_load) begin
        r_tx_shift  <= r_hold_full ? r_hold : '0;
        r_hold_full <= 1'b0;
      end else if (w_shift) begin
        r_tx_shift <= w_tx_adv;
      end
      if (bus.tx_valid && !r_hold_full) begin
        r_hold      <= bus.tx_data;
        r_hold_full <= 1'b1;
      end

      // With CPHA=0 the first edge after frame start samples, so the
      // following drive edge must already shift.
      if (w_load) r_skip <= w_first ? (CPHA != 0) : 1'b1;
      else if (r_state == SHIFT && w_drive) r_skip <= 1'b0;

      if (w_first || w_done) r_bit_cnt <= '0;
      else if (w_smp)        r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_smp) r_rx_shift <= w_rx_next;

      if (w_done) begin
        r_rx_data  <= w_rx_next;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && bus.rx_ready) begin
        r_rx_valid <= 1'b0;
      end

      r_miso <= (r_state == SHIFT) ? w_tx_bit : 1'b0;
      r_oe   <= (r_state == SHIFT);
    end
  end

  assign bus.miso        = r_miso;
  assign bus.miso_oe     = r_oe;
  assign bus.tx_ready    = ~r_hold_full;
  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.busy        = (r_state != IDLE);
  assign bus.tx_underrun = r_underrun;
  assign bus.rx_overrun  = r_overrun;
  assign bus.frame_abort = r_abort;
endmodule

// File: tb/tb_spi_slave_stream.sv
// Scoreboard bench for spi_slave_stream: mode 0 MSB-first and mode 3 LSB-first
// instances driven by a bit-banged master; rx words checked by a monitor.
`timescale 1ns/1ps
module tb_spi_slave_stream;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_slave_stream_if #(.DATA_WIDTH(16)) b0 ();
  spi_slave_stream_if #(.DATA_WIDTH(16)) b3 ();

  spi_slave_stream #(
    .DATA_WIDTH(16), .CPOL(0), .CPHA(0),
    .LSB_FIRST(0), .SYNC_STAGES(2)
  ) u0 (
    .clk(clk), .reset(rst_n), .bus(b0.slave)
  );

  spi_slave_stream #(
    .DATA_WIDTH(16), .CPOL(1), .CPHA(1),
    .LSB_FIRST(1), .SYNC_STAGES(2)
  ) u3 (
    .clk(clk), .reset(rst_n), .bus(b3.slave)
  );

  logic ph = 1'b0;
  logic mosi = 1'b0;
  logic cs0 = 1'b1, cs3 = 1'b1;
  logic [15:0] txd0 = '0, txd3 = '0;
  logic txv0 = 1'b0, txv3 = 1'b0;
  logic rr0 = 1'b1, rr3 = 1'b1;

  assign b0.sclk     = ph;
  assign b3.sclk     = ~ph;
  assign b0.mosi     = mosi;
  assign b3.mosi     = mosi;
  assign b0.cs_bar   = cs0;
  assign b3.cs_bar   = cs3;
  assign b0.tx_data  = txd0;
  assign b3.tx_data  = txd3;
  assign b0.tx_valid = txv0;
  assign b3.tx_valid = txv3;
  assign b0.rx_ready = rr0;
  assign b3.rx_ready = rr3;

  int total = 0;
  int bad = 0;
  int n_unr = 0, n_ovr = 0, n_abt = 0;
  logic [15:0] q0[$];
  logic [15:0] q3[$];
  logic [15:0] cap, c1, c2;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (b0.tx_underrun || b3.tx_underrun) n_unr++;
    if (b0.rx_overrun || b3.rx_overrun) n_ovr++;
    if (b0.frame_abort || b3.frame_abort) n_abt++;
    if (b0.rx_valid && rr0) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx0 extra: got %h want none", b0.rx_data);
      end else chk("rx0 word", b0.rx_data, q0.pop_front());
    end
    if (b3.rx_valid && rr3) begin
      if (q3.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx3 extra: got %h want none", b3.rx_data);
      end else chk("rx3 word", b3.rx_data, q3.pop_front());
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cs_set(input int sel, input logic v);
    if (sel == 0) cs0 = v;
    else cs3 = v;
  endtask

  task automatic start(input int sel);
    cs_set(sel, 1'b0);
    cyc(10);
  endtask

  task automatic stop(input int sel);
    cyc(10);
    cs_set(sel, 1'b1);
    cyc(20);
  endtask

  task automatic push_tx(input int sel, input logic [15:0] d);
    int t;
    t = 0;
    while (!(sel == 0 ? b0.tx_ready : b3.tx_ready) && t < 500) begin
      cyc(1);
      t++;
    end
    if (t >= 500) begin
      total++;
      bad++;
      $display("FAIL tx_ready timeout: got 0 want 1");
    end else begin
      if (sel == 0) begin txd0 = d; txv0 = 1'b1; end
      else begin txd3 = d; txv3 = 1'b1; end
      cyc(1);
      txv0 = 1'b0;
      txv3 = 1'b0;
    end
  endtask

  task automatic xfer(input int sel, input logic [15:0] w,
                      input int nbits, output logic [15:0] c);
    int idx;
    c = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = (sel == 0) ? 15 - i : i;
      if (sel == 0) begin
        mosi = w[idx];
        cyc(HALF);
        c[idx] = b0.miso;
        ph = 1'b1;
        cyc(HALF);
        ph = 1'b0;
      end else begin
        ph = 1'b1;
        mosi = w[idx];
        cyc(HALF);
        c[idx] = b3.miso;
        ph = 1'b0;
        cyc(HALF);
      end
    end
  endtask

  initial begin
    cyc(3);
    chk("rst miso", b0.miso, 0);
    chk("rst oe", b0.miso_oe, 0);
    chk("rst rx_valid", b0.rx_valid, 0);
    chk("rst busy", b0.busy, 0);
    chk("rst tx_ready", b0.tx_ready, 1);
    chk("rst rx_data", b0.rx_data, 0);
    rst_n = 1'b1;
    cyc(5);

    // mode 0 single word
    push_tx(0, 16'hA5C3);
    chk("t1 oe idle", b0.miso_oe, 0);
    start(0);
    chk("t1 oe frame", b0.miso_oe, 1);
    chk("t1 busy", b0.busy, 1);
    q0.push_back(16'h1234);
    xfer(0, 16'h1234, 16, cap);
    stop(0);
    chk("t1 miso word", cap, 16'hA5C3);
    chk("t1 oe after", b0.miso_oe, 0);
    chk("t1 busy after", b0.busy, 0);
    chk("t1 rx drained", q0.size(), 0);

    // mode 3 LSB first, two words streamed
    push_tx(3, 16'h00FF);
    n_unr = 0;
    start(3);
    q3.push_back(16'hBEEF);
    q3.push_back(16'h0001);
    fork
      begin
        xfer(3, 16'hBEEF, 16, c1);
        xfer(3, 16'h0001, 16, c2);
      end
      begin
        cyc(40);
        push_tx(3, 16'h8001);
        cyc(300);
        push_tx(3, 16'h4242);
      end
    join
    stop(3);
    chk("t2 miso w1", c1, 16'h00FF);
    chk("t2 miso w2", c2, 16'h8001);
    chk("t2 underruns", n_unr, 0);
    chk("t2 rx drained", q3.size(), 0);

    // underrun at frame start
    n_unr = 0;
    start(0);
    q0.push_back(16'hC0DE);
    fork
      xfer(0, 16'hC0DE, 16, cap);
      begin
        cyc(40);
        push_tx(0, 16'h7777);
      end
    join
    stop(0);
    chk("t3 miso zero", cap, 16'h0000);
    chk("t3 underruns", n_unr, 1);
    chk("t3 rx drained", q0.size(), 0);

    // abort after 7 bits, then a clean frame
    n_abt = 0;
    start(0);
    xfer(0, 16'hFFFF, 7, cap);
    stop(0);
    chk("t4 aborts", n_abt, 1);
    chk("t4 rx_valid", b0.rx_valid, 0);
    push_tx(0, 16'h6C6C);
    start(0);
    q0.push_back(16'h5A5A);
    xfer(0, 16'h5A5A, 16, cap);
    stop(0);
    chk("t4 miso word", cap, 16'h6C6C);
    chk("t4 aborts after", n_abt, 1);
    chk("t4 rx drained", q0.size(), 0);

    // overrun with rx_ready held low
    rr0 = 1'b0;
    n_ovr = 0;
    start(0);
    q0.push_back(16'h2222);
    xfer(0, 16'h1111, 16, cap);
    xfer(0, 16'h2222, 16, cap);
    stop(0);
    chk("t5 overruns", n_ovr, 1);
    chk("t5 rx_data", b0.rx_data, 16'h2222);
    chk("t5 rx_valid", b0.rx_valid, 1);
    rr0 = 1'b1;
    cyc(1);
    chk("t5 rx_valid clr", b0.rx_valid, 0);
    chk("t5 rx drained", q0.size(), 0);

    // reset mid-word, remainder ignored, then a fresh frame
    start(0);
    xfer(0, 16'hFFFF, 9, cap);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6 miso", b0.miso, 0);
    chk("t6 oe", b0.miso_oe, 0);
    chk("t6 busy", b0.busy, 0);
    chk("t6 rx_data", b0.rx_data, 0);
    chk("t6 tx_ready", b0.tx_ready, 1);
    cyc(3);
    rst_n = 1'b1;
    n_abt = 0;
    n_unr = 0;
    xfer(0, 16'hFFFF, 7, cap);
    chk("t6 ignored busy", b0.busy, 0);
    stop(0);
    chk("t6 aborts", n_abt, 0);
    chk("t6 underruns", n_unr, 0);
    push_tx(0, 16'h3C3C);
    start(0);
    q0.push_back(16'h0F0F);
    xfer(0, 16'h0F0F, 16, cap);
    stop(0);
    chk("t6 miso word", cap, 16'h3C3C);
    chk("t6 rx drained", q0.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
